// File: rtl/coef_rom_pkg.sv
// Shared types and widths for the coefficient ROM burst arbiter.
package coef_rom_pkg;

    localparam int COEF_AW  = 8;
    localparam int COEF_DW  = 16;
    // Tag id is sized for the largest supported requester count (4).
    localparam int COEF_IDW = 2;

    typedef struct packed {
        logic [COEF_IDW-1:0] id;
        logic                last;
    } coef_tag_t;

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } coef_arb_state_e;

endpackage

// File: rtl/coef_rom_arbiter_if.sv
// Request, ROM and response signals of the coefficient ROM arbiter.
interface coef_rom_arbiter_if
    import coef_rom_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int AW    = COEF_AW,
    parameter int DW    = COEF_DW
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*AW-1:0] req_base;
    logic [N_REQ*AW-1:0] req_len;

    logic [AW-1:0]       rom_a;
    logic                rom_cen;
    logic [DW-1:0]       rom_q;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [DW-1:0]       rsp_data;
    logic [IDW-1:0]      rsp_id;
    logic                rsp_last;
    logic                busy;

    modport slave (
        input  req_valid, req_base, req_len, rom_q, rsp_ready,
        output req_ready, rom_a, rom_cen, rsp_valid, rsp_data, rsp_id, rsp_last, busy
    );

    modport master (
        output req_valid, req_base, req_len, rom_q, rsp_ready,
        input  req_ready, rom_a, rom_cen, rsp_valid, rsp_data, rsp_id, rsp_last, busy
    );

endinterface

// File: rtl/coef_rsp_fifo.sv
// Two-entry response FIFO carrying ROM data plus its {id, last} tag.
module coef_rsp_fifo
    import coef_rom_pkg::*;
#(
    parameter int DW = COEF_DW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  coef_tag_t     tag_i,
    input  logic          pop_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output coef_tag_t     tag_o,
    output logic [1:0]    occ_o
);

    logic [DW-1:0] data_q [2];
    coef_tag_t     tag_q  [2];
    logic          wr_q, wr_d;
    logic          rd_q, rd_d;
    logic [1:0]    occ_q, occ_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop  = pop_i && (occ_q != 2'd0);
        do_push = push_i && ((occ_q != 2'd2) || do_pop);
        wr_d    = do_push ? ~wr_q : wr_q;
        rd_d    = do_pop  ? ~rd_q : rd_q;
        occ_d   = occ_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            occ_q <= '0;
        end else begin
            if (do_push) begin
                data_q[wr_q] <= data_i;
                tag_q[wr_q]  <= tag_i;
            end
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            occ_q <= occ_d;
        end
    end

    assign valid_o = (occ_q != 2'd0);
    assign data_o  = data_q[rd_q];
    assign tag_o   = tag_q[rd_q];
    assign occ_o   = occ_q;

endmodule

// File: rtl/coef_rom_arbiter.sv
// Round-robin burst-read arbiter sharing one registered coefficient ROM.
module coef_rom_arbiter
    import coef_rom_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int AW    = COEF_AW,
    parameter int DW    = COEF_DW
) (
    input  logic               clk,
    input  logic               reset_n,
    coef_rom_arbiter_if.slave  bus
);

    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int RW  = AW + 1;

    coef_arb_state_e     state_q, state_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [RW-1:0]       remain_q, remain_d;
    logic [COEF_IDW-1:0] id_q, id_d;
    logic [IDW-1:0]      last_grant_q, last_grant_d;
    logic                inflight_q;
    coef_tag_t           tag_q, tag_d;

    logic [IDW-1:0]      cand;
    logic [IDW-1:0]      grant_idx;
    logic                grant_found;
    logic [N_REQ-1:0]    req_ready_c;
    logic [AW-1:0]       grant_len;
    logic                issue;
    logic                pop;
    logic [2:0]          credit_used;

    logic                fifo_valid;
    logic [DW-1:0]       fifo_data;
    coef_tag_t           fifo_tag;
    logic [1:0]          occ;
    logic                unused_tag_id;

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        cand        = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = IDW'((int'(last_grant_q) + int'(k)) % N_REQ);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign pop         = fifo_valid && bus.rsp_ready;
    assign credit_used = {1'b0, occ} + {2'b00, inflight_q};
    assign grant_len   = bus.req_len[int'(grant_idx)*AW +: AW];

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        remain_d     = remain_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        req_ready_c  = '0;
        issue        = 1'b0;
        tag_d        = '{id: id_q, last: (remain_q == RW'(1))};

        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    req_ready_c[grant_idx] = 1'b1;
                    addr_d       = bus.req_base[int'(grant_idx)*AW +: AW];
                    remain_d     = (grant_len == '0) ? RW'(2**AW) : {1'b0, grant_len};
                    id_d         = COEF_IDW'(grant_idx);
                    last_grant_d = grant_idx;
                    state_d      = ST_BURST;
                end
            end
            ST_BURST: begin
                // A same-cycle pop frees a slot, so it counts as credit immediately.
                if (credit_used < (3'd2 + {2'b00, pop})) begin
                    issue    = 1'b1;
                    addr_d   = addr_q + AW'(1);
                    remain_d = remain_q - RW'(1);
                    if (remain_q == RW'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            remain_q     <= '0;
            id_q         <= '0;
            last_grant_q <= IDW'(N_REQ - 1);
            inflight_q   <= 1'b0;
            tag_q        <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remain_q     <= remain_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            inflight_q   <= issue;
            tag_q        <= tag_d;
        end
    end

    coef_rsp_fifo #(.DW(DW)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (inflight_q),
        .data_i  (bus.rom_q),
        .tag_i   (tag_q),
        .pop_i   (pop),
        .valid_o (fifo_valid),
        .data_o  (fifo_data),
        .tag_o   (fifo_tag),
        .occ_o   (occ)
    );

    assign unused_tag_id = ^fifo_tag.id;

    assign bus.req_ready = req_ready_c;
    assign bus.rom_cen   = issue;
    assign bus.rom_a     = addr_q;
    assign bus.rsp_valid = fifo_valid;
    assign bus.rsp_data  = fifo_data;
    assign bus.rsp_id    = fifo_tag.id[IDW-1:0];
    assign bus.rsp_last  = fifo_tag.last;
    assign bus.busy      = (state_q == ST_BURST) | inflight_q | (occ != 2'd0);

endmodule

// File: tb/tb_coef_rom_arbiter.sv
// Scoreboard bench for coef_rom_arbiter: directed bursts, expected words queued at stimulus time.
module tb_coef_rom_arbiter;
    import coef_rom_pkg::*;

    localparam int N = 2;

    typedef struct packed {
        logic [15:0] d;
        logic [0:0]  id;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_pop_cyc = 0;

    exp_t       exp_q[$];
    logic [7:0] addr_log[$];

    coef_rom_arbiter_if #(.N_REQ(N), .AW(8), .DW(16)) bus ();

    coef_rom_arbiter #(.N_REQ(N), .AW(8), .DW(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] rom_word(input logic [7:0] a);
        case (a)
            8'h03:   rom_word = 16'ha9c0;
            8'h04:   rom_word = 16'ha7d0;
            8'h05:   rom_word = 16'h962e;
            8'h06:   rom_word = 16'ha3e4;
            default: rom_word = {a ^ 8'h5a, ~a};
        endcase
    endfunction

    // Registered ROM model: output updates only on enabled reads.
    always @(posedge clk) if (bus.rom_cen) bus.rom_q <= rom_word(bus.rom_a);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: buffer occupancy model, hold stability, address log, scoreboard pop.
    int         m_occ = 0;
    logic       m_infl = 1'b0;
    logic       held_v = 1'b0;
    logic [17:0] held;
    always @(negedge clk) begin
        logic pop;
        int   credit;
        exp_t e;
        if (!reset_n) begin
            m_occ  = 0;
            m_infl = 1'b0;
            held_v = 1'b0;
        end else begin
            chk("occ_bound", 64'(m_occ <= 2), 64'd1);
            chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_occ != 0));
            pop    = (m_occ != 0) && bus.rsp_ready;
            credit = m_occ + int'(m_infl) - int'(pop);
            if (credit >= 2) chk("cen_when_full", 64'(bus.rom_cen), 64'd0);
            if (held_v)
                chk("hold", {bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_last}, {1'b1, held});
            held_v = bus.rsp_valid && !bus.rsp_ready;
            held   = {bus.rsp_data, bus.rsp_id, bus.rsp_last};
            if (bus.rom_cen) addr_log.push_back(bus.rom_a);
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_extra: got word %h id %0d last %0d, expected none",
                             bus.rsp_data, bus.rsp_id, bus.rsp_last);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_word", {bus.rsp_data, bus.rsp_id, bus.rsp_last}, e);
                    if (bus.rsp_last) last_pop_cyc = cyc;
                end
            end
            m_occ  = m_occ + int'(m_infl) - int'(pop);
            m_infl = bus.rom_cen;
        end
    end

    task automatic post(input int r, input logic [7:0] b, input logic [7:0] l);
        bus.req_base[r*8 +: 8] = b;
        bus.req_len[r*8 +: 8]  = l;
        bus.req_valid[r]       = 1'b1;
    endtask

    task automatic expect_burst(input int r, input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back('{d: rom_word(b + 8'(i)), id: 1'(r), last: (i == n - 1)});
    endtask

    task automatic wait_hs(input int r, output int t);
        int n = 0;
        t = -1;
        while (n < 600) begin
            @(negedge clk);
            if (bus.req_valid[r] && bus.req_ready[r]) begin
                t = cyc;
                break;
            end
            n++;
        end
        if (t < 0) begin
            checks++;
            errors++;
            $display("FAIL hs_timeout: requester %0d got no grant, expected one", r);
        end else begin
            chk("ready_onehot", 64'(bus.req_ready), 64'(1 << r));
            @(posedge clk);
            #1 bus.req_valid[r] = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3 reset_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0, t1, t2, n;
        reset_n       = 1'b0;
        bus.req_valid = '0;
        bus.req_base  = '0;
        bus.req_len   = '0;
        bus.rsp_ready = 1'b1;
        #1;
        chk("reset_outputs", {bus.req_ready, bus.rom_a, bus.rom_cen, bus.rsp_valid,
                              bus.rsp_data, bus.rsp_id, bus.rsp_last, bus.busy}, '0);
        #21 reset_n = 1'b1;

        // Single burst with known ROM words and latency.
        @(posedge clk); #1;
        exp_q.push_back('{d: 16'ha9c0, id: 1'b0, last: 1'b0});
        exp_q.push_back('{d: 16'ha7d0, id: 1'b0, last: 1'b0});
        exp_q.push_back('{d: 16'h962e, id: 1'b0, last: 1'b0});
        exp_q.push_back('{d: 16'ha3e4, id: 1'b0, last: 1'b1});
        post(0, 8'h03, 8'd4);
        wait_hs(0, t0);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("first_latency", 64'(cyc - t0), 64'd3);
        drain();
        chk("last_word_cycle", 64'(last_pop_cyc - t0), 64'd6);

        // Simultaneous requests after reset, then round-robin rotation.
        pulse_reset();
        expect_burst(0, 8'h10, 2);
        expect_burst(1, 8'h20, 2);
        expect_burst(0, 8'h10, 2);
        post(0, 8'h10, 8'd2);
        post(1, 8'h20, 8'd2);
        wait_hs(0, t0);
        post(0, 8'h10, 8'd2);
        wait_hs(1, t1);
        chk("rr_gap_req1", 64'(t1 - t0), 64'd3);
        wait_hs(0, t2);
        chk("rr_gap_req0", 64'(t2 - t1), 64'd3);
        drain();

        // Backpressure: consumer stalls for cycles T+3..T+8.
        @(posedge clk); #1;
        addr_log.delete();
        expect_burst(0, 8'h40, 6);
        post(0, 8'h40, 8'd6);
        wait_hs(0, t0);
        repeat (2) @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        drain();
        chk("bp_issue_count", 64'(addr_log.size()), 64'd6);

        // Address wrap past 8'hff.
        @(posedge clk); #1;
        addr_log.delete();
        expect_burst(1, 8'hfe, 3);
        post(1, 8'hfe, 8'd3);
        wait_hs(1, t0);
        drain();
        chk("wrap_count", 64'(addr_log.size()), 64'd3);
        if (addr_log.size() == 3)
            chk("wrap_addrs", {addr_log[0], addr_log[1], addr_log[2]}, 64'hfeff00);

        // len=0 means a full 256-word burst.
        @(posedge clk); #1;
        expect_burst(1, 8'h80, 256);
        post(1, 8'h80, 8'd0);
        wait_hs(1, t0);
        drain();
        chk("busy_after_256", 64'(bus.busy), 64'd0);

        // Asynchronous reset in the middle of a burst.
        @(posedge clk); #1;
        expect_burst(0, 8'h30, 8);
        post(0, 8'h30, 8'd8);
        wait_hs(0, t0);
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("midreset_outputs", {bus.req_ready, bus.rom_a, bus.rom_cen, bus.rsp_valid,
                                 bus.rsp_data, bus.rsp_id, bus.rsp_last, bus.busy}, '0);
        exp_q.delete();
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk); #1;
        expect_burst(0, 8'h05, 1);
        post(0, 8'h05, 8'd1);
        wait_hs(0, t0);
        drain();
        chk("busy_after_reset", 64'(bus.busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/coef_rom_arbiter.md
# coef_rom_arbiter

Burst-read controller and round-robin arbiter that shares one registered coefficient ROM (8-bit address, 16-bit word, 1-cycle read latency, output held while `cen` low) between `N_REQ` requesters. Each requester posts a burst `(base, len)`. The block grants one burst at a time, sequences the ROM address/`cen`, and streams the returned words through a 2-entry credit-controlled output buffer. Output is a single valid/ready response channel tagged with the requester id. It sits between the filter/MAC engines and the ROM instance.

## Interface
- `N_REQ`, 2: number of requesters (2..4).
- `AW`, 8: ROM address width.
- `DW`, 16: ROM data width.
- `clk`  in  1  clock, all state on rising edge.
- `reset_n`  in  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `req_valid`  in  N_REQ  burst request per requester.
- `req_ready`  out  N_REQ  one-hot acceptance; reset 0.
- `req_base`  in  N_REQ*AW  start address per requester (requester i at slice i).
- `req_len`  in  N_REQ*AW  word count per requester; 0 encodes 2^AW.
- `rom_a`  out  AW  ROM address; reset 0.
- `rom_cen`  out  1  ROM read enable; reset 0.
- `rom_q`  in  DW  ROM data, valid the cycle after `rom_cen`.
- `rsp_valid`  out  1  response word available; reset 0.
- `rsp_ready`  in  1  consumer accepts word.
- `rsp_data`  out  DW  word; reset 0.
- `rsp_id`  out  $clog2(N_REQ)  owning requester; reset 0.
- `rsp_last`  out  1  final word of burst; reset 0.
- `busy`  out  1  burst active or words buffered/in flight; reset 0.

## Operation
- FSM with two states, IDLE and BURST. Reset state is IDLE.
- **IDLE, arbitration:**
  - Round-robin over asserted `req_valid`, starting at the index after `last_grant`. `last_grant` resets to N_REQ-1, so requester 0 wins first.
  - `req_ready[g]` is asserted combinationally in IDLE for the winner only.
  - On handshake, latch `addr<=base`, `remain<=len` (0 means 2^AW), `id<=g`, `last_grant<=g`, then go to BURST.
- **BURST, issue:**
  - Issue a read (`rom_cen=1`, `rom_a=addr`) when `occ + inflight - pop < 2`.
    - `occ` = buffer count.
    - `inflight` = 1 if `rom_cen` was high last cycle.
    - `pop` = `rsp_valid && rsp_ready`.
  - On issue: `addr` increments modulo 2^AW (wrap, no error) and `remain` decrements.
  - The issue that takes `remain` to 0 returns the FSM to IDLE.
- **Tagging:** each issue carries a pipeline tag `{id, last}` that travels with the read. `last` = (remain==1).
- **Capture:** the cycle after issue, `rom_q` and its tag are written into the 2-entry FIFO. The head drives `rsp_*`.
- **Overflow:** impossible by the credit rule; the bench asserts it never occurs.
- **Overlap:** a new burst may be granted while the previous burst's words are still buffered. Words stay in order; `rsp_id` and `rsp_last` stay correct per word.
- **Busy:** `busy` = (state==BURST) | inflight | (occ!=0).
- **Async reset mid-burst:** FSM, counters, FIFO, tag pipeline and `last_grant` clear immediately. The pending burst is dropped with no partial `rsp_last`.

## Timing
- Handshake in cycle T. First `rom_cen` in T+1. Word captured at end of T+2. `rsp_valid` high in T+3, so latency is 3 cycles.
- With `rsp_ready` held high the throughput is 1 word/cycle: a burst of L words occupies `rom_cen` for L consecutive cycles.
- With `rsp_ready` low the FIFO fills (2 words) and `rom_cen` drops. Issue resumes in the cycle `rsp_ready` returns (pop credited the same cycle).
- One idle cycle separates the last issue of a burst from the first issue of the next. Grant occurs in IDLE; issue starts the following cycle.
- `req_valid` may deassert without a handshake; the arbiter re-evaluates every IDLE cycle.
- `rsp_data`, `rsp_id` and `rsp_last` are held stable while `rsp_valid && !rsp_ready`.

## Structure
- Package `coef_rom_pkg`:
  - `localparam`s `COEF_AW=8`, `COEF_DW=16`.
  - Typedef `coef_tag_t` (`id`, `last`).
  - FSM enum `coef_arb_state_e`.
- Sub-module `coef_rsp_fifo`: 2-entry FIFO with data+tag payload and `occ` output, async active-low reset.
- Arbiter, issue logic and tag pipeline stay inline in the top module.
- The ROM is instantiated outside this block.

## Test plan
- **Single burst:** req0 base=3, len=4, `rsp_ready`=1, ROM model = table (word 3 = 16'ha9c0). Expect `rsp_data` a9c0,a7d0,962e,a3e4 in T+3..T+6, `rsp_id`=0, `rsp_last` on the 4th word only.
- **Simultaneous requests after reset:** req0 and req1 both len=2. Expect req0 granted first, req1 one cycle after req0's last issue. Then repeat both requests: expect req1 granted before req0.
- **Backpressure:** len=6, `rsp_ready` low for cycles T+3..T+8. Expect ≤2 buffered words, `rom_cen` low while full, all 6 words delivered in order with no loss or duplication.
- **Wrap:** base=8'hfe, len=3. Expect `rom_a` sequence fe, ff, 00.
- **len=0:** expect exactly 256 words with `rsp_last` on the 256th and `busy` low afterwards.
- **Reset mid-burst:** assert `reset_n`=0 during an active burst. Expect all outputs 0 asynchronously; after release, a new len=1 burst completes normally.
